// File: rtl/rename_map_unit.sv
// Multi-lane register rename unit: speculative/committed arch->phys maps, circular free list,
// single-cycle flush recovery and a one-deep registered output bank.
module rename_map_unit #(
  parameter int NUM_PHYREG   = 128,
  parameter int NUM_ARCHREG  = 32,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int ROBW         = 6,
  localparam int PW  = $clog2(NUM_PHYREG),
  localparam int AW  = $clog2(NUM_ARCHREG),
  localparam int FLD = NUM_PHYREG - NUM_ARCHREG,
  localparam int CW  = $clog2(FLD + 1)
) (
  input  logic                                  SIG_CLK,
  input  logic                                  SIG_RST,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [RENAME_WIDTH-1:0]               in_lane_valid,
  input  logic [RENAME_WIDTH-1:0][ROBW-1:0]     in_rob_idx,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]       in_dst_arch,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]       in_src1_arch,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]       in_src2_arch,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [RENAME_WIDTH-1:0]               out_lane_valid,
  output logic [RENAME_WIDTH-1:0][ROBW-1:0]     out_rob_idx,
  output logic [RENAME_WIDTH-1:0][PW-1:0]       out_dst_phy,
  output logic [RENAME_WIDTH-1:0][PW-1:0]       out_src1_phy,
  output logic [RENAME_WIDTH-1:0][PW-1:0]       out_src2_phy,
  output logic [RENAME_WIDTH-1:0][PW-1:0]       out_prev_phy,
  input  logic [COMMIT_WIDTH-1:0]               commit_valid,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]       commit_dst_arch,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]       commit_dst_phy,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]       commit_prev_phy,
  input  logic                                  flush,
  output logic [CW-1:0]                         free_count
);
  localparam int IW = $clog2(FLD);
  typedef logic [IW:0] ptr_t;  // {wrap, index}

  typedef struct packed {
    logic [PW-1:0] dst;
    logic [PW-1:0] src1;
    logic [PW-1:0] src2;
    logic [PW-1:0] prev;
  } laneOut_t;

  // FLD need not be a power of two, so wrap the index explicitly and toggle the wrap bit.
  function automatic ptr_t ptrAdd(ptr_t p, int n);
    logic [IW+2:0] idx;
    logic          wrap;
    idx  = (IW+3)'(p[IW-1:0]) + (IW+3)'(n);
    wrap = p[IW];
    if (idx >= (IW+3)'(FLD)) begin
      idx  = idx - (IW+3)'(FLD);
      wrap = ~wrap;
    end
    return {wrap, idx[IW-1:0]};
  endfunction

  logic [NUM_ARCHREG-1:0][PW-1:0] specMap, commitMap, commitMapNext;
  logic [PW-1:0]                  fl [FLD];
  ptr_t                           specHead, commitHead, tail;
  ptr_t                           commitHeadNext, tailNext, allocPtr, slotPtr;
  int                             fc, need, nCommit;
  logic                           accept;
  logic [RENAME_WIDTH-1:0]        alloc;
  logic [RENAME_WIDTH-1:0][PW-1:0] newPhy;
  laneOut_t [RENAME_WIDTH-1:0]    ren;
  logic [COMMIT_WIDTH-1:0]        cDo;
  logic [COMMIT_WIDTH-1:0][IW-1:0] cSlot;

  always_comb begin
    if (tail[IW] == specHead[IW]) fc = int'(tail[IW-1:0]) - int'(specHead[IW-1:0]);
    else                          fc = FLD + int'(tail[IW-1:0]) - int'(specHead[IW-1:0]);
  end
  assign free_count = CW'(fc);

  // Lane j sees the newest allocation of any older lane in the group before the spec map.
  always_comb begin
    need     = 0;
    alloc    = '0;
    newPhy   = '0;
    ren      = '0;
    allocPtr = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      alloc[j]    = in_lane_valid[j] && (in_dst_arch[j] != '0);
      allocPtr    = ptrAdd(specHead, need);
      newPhy[j]   = fl[allocPtr[IW-1:0]];
      if (alloc[j]) need = need + 1;
      ren[j].src1 = specMap[in_src1_arch[j]];
      ren[j].src2 = specMap[in_src2_arch[j]];
      ren[j].prev = alloc[j] ? specMap[in_dst_arch[j]] : '0;
      ren[j].dst  = alloc[j] ? newPhy[j] : '0;
      for (int i = 0; i < j; i++) begin
        if (alloc[i]) begin
          if (in_dst_arch[i] == in_src1_arch[j]) ren[j].src1 = newPhy[i];
          if (in_dst_arch[i] == in_src2_arch[j]) ren[j].src2 = newPhy[i];
          if (alloc[j] && in_dst_arch[i] == in_dst_arch[j]) ren[j].prev = newPhy[i];
        end
      end
    end
  end

  assign in_ready = !flush && (fc >= need) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    commitMapNext = commitMap;
    nCommit       = 0;
    cDo           = '0;
    cSlot         = '0;
    slotPtr       = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      cDo[k]   = commit_valid[k] && (commit_dst_arch[k] != '0);
      slotPtr  = ptrAdd(tail, nCommit);
      cSlot[k] = slotPtr[IW-1:0];
      if (cDo[k]) begin
        commitMapNext[commit_dst_arch[k]] = commit_dst_phy[k];
        nCommit = nCommit + 1;
      end
    end
    commitHeadNext = ptrAdd(commitHead, nCommit);
    tailNext       = ptrAdd(tail, nCommit);
  end

  always_ff @(posedge SIG_CLK) begin
    if (SIG_RST) begin
      for (int i = 0; i < NUM_ARCHREG; i++) begin
        specMap[i]   <= PW'(i);
        commitMap[i] <= PW'(i);
      end
      for (int k = 0; k < FLD; k++) fl[k] <= PW'(NUM_ARCHREG + k);
      specHead   <= '0;
      commitHead <= '0;
      tail       <= {1'b1, {IW{1'b0}}};
    end else begin
      commitMap  <= commitMapNext;
      commitHead <= commitHeadNext;
      tail       <= tailNext;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (cDo[k]) fl[cSlot[k]] <= commit_prev_phy[k];
      if (flush) begin
        specMap  <= commitMapNext;
        specHead <= commitHeadNext;
      end else if (accept) begin
        for (int j = 0; j < RENAME_WIDTH; j++)
          if (alloc[j]) specMap[in_dst_arch[j]] <= newPhy[j];
        specHead <= ptrAdd(specHead, need);
      end
    end
  end

  always_ff @(posedge SIG_CLK) begin
    if (SIG_RST) begin
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_rob_idx    <= '0;
      out_dst_phy    <= '0;
      out_src1_phy   <= '0;
      out_src2_phy   <= '0;
      out_prev_phy   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_lane_valid <= in_lane_valid;
      out_rob_idx    <= in_rob_idx;
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        out_dst_phy[j]  <= ren[j].dst;
        out_src1_phy[j] <= ren[j].src1;
        out_src2_phy[j] <= ren[j].src2;
        out_prev_phy[j] <= ren[j].prev;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Committing more registers than are in flight would overrun the free list.
  always_ff @(posedge SIG_CLK) begin
    if (!SIG_RST) assert (fc + nCommit <= FLD);
  end
endmodule

// File: tb/tb_rename_map_unit.sv
// Randomised and directed bench for rename_map_unit against a queue-based rename model.
module tb_rename_map_unit;
  localparam int NP = 128, NA = 32, RW = 2, CWD = 2, ROBW = 6;
  localparam int PW = $clog2(NP), AW = $clog2(NA), FLD = NP - NA, CW = $clog2(FLD + 1);

  logic SIG_CLK, SIG_RST;
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [RW-1:0]            in_lane_valid, out_lane_valid;
  logic [RW-1:0][ROBW-1:0]  in_rob_idx, out_rob_idx;
  logic [RW-1:0][AW-1:0]    in_dst_arch, in_src1_arch, in_src2_arch;
  logic [RW-1:0][PW-1:0]    out_dst_phy, out_src1_phy, out_src2_phy, out_prev_phy;
  logic [CWD-1:0]           commit_valid;
  logic [CWD-1:0][AW-1:0]   commit_dst_arch;
  logic [CWD-1:0][PW-1:0]   commit_dst_phy, commit_prev_phy;
  logic [CW-1:0]            free_count;

  rename_map_unit #(.NUM_PHYREG(NP), .NUM_ARCHREG(NA), .RENAME_WIDTH(RW),
                    .COMMIT_WIDTH(CWD), .ROBW(ROBW)) dut (
    .SIG_CLK(SIG_CLK), .SIG_RST(SIG_RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_rob_idx(in_rob_idx), .in_dst_arch(in_dst_arch),
    .in_src1_arch(in_src1_arch), .in_src2_arch(in_src2_arch), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_valid(out_lane_valid), .out_rob_idx(out_rob_idx),
    .out_dst_phy(out_dst_phy), .out_src1_phy(out_src1_phy), .out_src2_phy(out_src2_phy),
    .out_prev_phy(out_prev_phy), .commit_valid(commit_valid), .commit_dst_arch(commit_dst_arch),
    .commit_dst_phy(commit_dst_phy), .commit_prev_phy(commit_prev_phy), .flush(flush),
    .free_count(free_count));

  initial SIG_CLK = 1'b0;
  always #5 SIG_CLK = ~SIG_CLK;

  // Model: flq holds the list from the oldest uncommitted allocation to the tail;
  // the first specOff entries are allocated but not yet committed.
  typedef struct {int arch; int phy; int prev;} inflight_t;
  int        specMap[NA], commitMap[NA];
  int        flq[$];
  int        specOff;
  inflight_t inflight[$];
  bit        expValid;
  logic [RW-1:0]           expLaneValid;
  logic [RW-1:0][ROBW-1:0] expRob;
  int        expDst[RW], expS1[RW], expS2[RW], expPrev[RW];
  int        errors = 0, checks = 0;

  task automatic modelReset();
    for (int i = 0; i < NA; i++) begin specMap[i] = i; commitMap[i] = i; end
    flq.delete();
    for (int k = 0; k < FLD; k++) flq.push_back(NA + k);
    specOff = 0;
    inflight.delete();
    expValid = 0;
  endtask

  task automatic clearInputs();
    in_valid = 0; in_lane_valid = '0; in_rob_idx = '0;
    in_dst_arch = '0; in_src1_arch = '0; in_src2_arch = '0;
    out_ready = 1; flush = 0;
    commit_valid = '0; commit_dst_arch = '0; commit_dst_phy = '0; commit_prev_phy = '0;
  endtask

  task automatic doReset();
    SIG_RST = 1;
    @(posedge SIG_CLK);
    @(negedge SIG_CLK);
    SIG_RST = 0;
    modelReset();
  endtask

  task automatic setLane(int j, bit v, int d, int s1, int s2);
    in_lane_valid[j] = v;
    in_dst_arch[j]   = AW'(d);
    in_src1_arch[j]  = AW'(s1);
    in_src2_arch[j]  = AW'(s2);
    in_rob_idx[j]    = ROBW'($urandom);
  endtask

  task automatic randGroup(int pDst0);
    for (int j = 0; j < RW; j++)
      setLane(j, $urandom_range(0, 3) != 0,
              ($urandom_range(0, pDst0) == 0) ? 0 : $urandom_range(1, NA - 1),
              $urandom_range(0, NA - 1), $urandom_range(0, NA - 1));
  endtask

  // Commit the n oldest in-flight allocations; optionally add an ignored dst-0 lane.
  task automatic setCommit(int n, bit dummy);
    inflight_t e;
    commit_valid = '0;
    for (int k = 0; k < CWD; k++) begin
      if (k < n && inflight.size() > 0) begin
        e = inflight.pop_front();
        commit_valid[k] = 1; commit_dst_arch[k] = AW'(e.arch);
        commit_dst_phy[k] = PW'(e.phy); commit_prev_phy[k] = PW'(e.prev);
      end else if (dummy) begin
        dummy = 0;
        commit_valid[k] = 1; commit_dst_arch[k] = '0;
        commit_dst_phy[k] = PW'($urandom); commit_prev_phy[k] = PW'($urandom);
      end
    end
  endtask

  // One clock: predict handshake and free count, advance the model, then check the output bank.
  task automatic step();
    int need, d, nw, pv;
    bit expReady, acc;
    int tmp[NA];
    #1;
    need = 0;
    for (int j = 0; j < RW; j++) if (in_lane_valid[j] && in_dst_arch[j] != 0) need++;
    expReady = !flush && (FLD - specOff >= need) && (!expValid || out_ready);
    checks++;
    if (in_ready !== expReady) begin
      errors++; $display("FAIL in_ready: got %b want %b", in_ready, expReady);
    end
    checks++;
    if (free_count !== CW'(FLD - specOff)) begin
      errors++; $display("FAIL free_count: got %0d want %0d", free_count, FLD - specOff);
    end
    acc = in_valid && expReady;
    if (acc) begin
      for (int i = 0; i < NA; i++) tmp[i] = specMap[i];
      for (int j = 0; j < RW; j++) begin
        if (in_lane_valid[j]) begin
          expS1[j] = (in_src1_arch[j] == 0) ? 0 : tmp[in_src1_arch[j]];
          expS2[j] = (in_src2_arch[j] == 0) ? 0 : tmp[in_src2_arch[j]];
          d = in_dst_arch[j];
          if (d != 0) begin
            pv = tmp[d]; nw = flq[specOff]; specOff++; tmp[d] = nw;
            inflight.push_back('{d, nw, pv});
          end else begin
            pv = 0; nw = 0;
          end
          expDst[j] = nw; expPrev[j] = pv;
        end
      end
      for (int i = 0; i < NA; i++) specMap[i] = tmp[i];
      expValid = 1; expLaneValid = in_lane_valid; expRob = in_rob_idx;
    end else if (out_ready) expValid = 0;
    for (int k = 0; k < CWD; k++) begin
      if (commit_valid[k] && commit_dst_arch[k] != 0) begin
        commitMap[commit_dst_arch[k]] = commit_dst_phy[k];
        void'(flq.pop_front());
        flq.push_back(commit_prev_phy[k]);
        specOff--;
      end
    end
    if (flush) begin
      for (int i = 0; i < NA; i++) specMap[i] = commitMap[i];
      specOff = 0; expValid = 0; inflight.delete();
    end
    @(posedge SIG_CLK);
    @(negedge SIG_CLK);
    commit_valid = '0; flush = 0;
    checks++;
    if (out_valid !== expValid) begin
      errors++; $display("FAIL out_valid: got %b want %b", out_valid, expValid);
    end
    if (expValid) begin
      checks++;
      if (out_lane_valid !== expLaneValid || out_rob_idx !== expRob) begin
        errors++; $display("FAIL passthru: got %b/%h want %b/%h", out_lane_valid, out_rob_idx, expLaneValid, expRob);
      end
      for (int j = 0; j < RW; j++) begin
        if (expLaneValid[j]) begin
          checks++;
          if (out_dst_phy[j] !== PW'(expDst[j]) || out_src1_phy[j] !== PW'(expS1[j]) ||
              out_src2_phy[j] !== PW'(expS2[j]) || out_prev_phy[j] !== PW'(expPrev[j])) begin
            errors++;
            $display("FAIL lane%0d phys: got d=%0d s1=%0d s2=%0d p=%0d want d=%0d s1=%0d s2=%0d p=%0d", j,
                     out_dst_phy[j], out_src1_phy[j], out_src2_phy[j], out_prev_phy[j],
                     expDst[j], expS1[j], expS2[j], expPrev[j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    clearInputs(); doReset(); #1;
    checks++;
    if ({out_valid, out_lane_valid, out_rob_idx, out_dst_phy, out_src1_phy, out_src2_phy, out_prev_phy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero want zero");
    end
    checks++;
    if (free_count !== CW'(FLD) || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: got fc=%0d rdy=%b want fc=%0d rdy=1", free_count, in_ready, FLD);
    end
  endtask

  task automatic test_single();
    clearInputs(); doReset();
    in_valid = 1; setLane(0, 1, 5, 1, 2); setLane(1, 0, 0, 0, 0);
    step();
    in_valid = 0;
    checks++;
    if (out_dst_phy[0] !== PW'(32) || out_src1_phy[0] !== PW'(1) || out_src2_phy[0] !== PW'(2) || out_prev_phy[0] !== PW'(5)) begin
      errors++; $display("FAIL single: got %0d/%0d/%0d/%0d want 32/1/2/5", out_dst_phy[0], out_src1_phy[0], out_src2_phy[0], out_prev_phy[0]);
    end
    checks++;
    if (free_count !== CW'(95)) begin
      errors++; $display("FAIL single_fc: got %0d want 95", free_count);
    end
    step();
  endtask

  task automatic test_dual();
    clearInputs(); doReset();
    in_valid = 1; setLane(0, 1, 3, 0, 0); setLane(1, 1, 3, 3, 4);
    step();
    checks++;
    if (out_dst_phy[0] !== PW'(32) || out_prev_phy[0] !== PW'(3) || out_src1_phy[1] !== PW'(32) ||
        out_dst_phy[1] !== PW'(33) || out_prev_phy[1] !== PW'(32)) begin
      errors++; $display("FAIL dual: got %0d/%0d %0d/%0d/%0d want 32/3 32/33/32", out_dst_phy[0], out_prev_phy[0],
                         out_src1_phy[1], out_dst_phy[1], out_prev_phy[1]);
    end
    setLane(0, 1, 0, 3, 0); setLane(1, 0, 0, 0, 0);
    step();
    in_valid = 0;
    checks++;
    if (out_src1_phy[0] !== PW'(33) || out_dst_phy[0] !== '0 || out_prev_phy[0] !== '0) begin
      errors++; $display("FAIL dual_map: got s1=%0d d=%0d p=%0d want 33/0/0", out_src1_phy[0], out_dst_phy[0], out_prev_phy[0]);
    end
    step();
  endtask

  task automatic test_exhaust();
    clearInputs(); doReset();
    in_valid = 1;
    for (int g = 0; g < FLD / 2; g++) begin
      setLane(0, 1, (g == 0) ? 3 : $urandom_range(1, NA - 1), $urandom_range(0, NA - 1), $urandom_range(0, NA - 1));
      setLane(1, 1, $urandom_range(1, NA - 1), $urandom_range(0, NA - 1), $urandom_range(0, NA - 1));
      step();
    end
    setLane(0, 1, 9, 1, 2); setLane(1, 0, 0, 0, 0);
    #1;
    checks++;
    if (free_count !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL exhaust_full: got fc=%0d rdy=%b want 0/0", free_count, in_ready);
    end
    step();
    setCommit(1, 0);
    step();
    #1;
    checks++;
    if (in_ready !== 1'b1 || free_count !== CW'(1)) begin
      errors++; $display("FAIL exhaust_free: got rdy=%b fc=%0d want 1/1", in_ready, free_count);
    end
    step();
    checks++;
    if (out_dst_phy[0] !== PW'(3)) begin
      errors++; $display("FAIL exhaust_wrap: got %0d want 3", out_dst_phy[0]);
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_flush();
    clearInputs(); doReset();
    in_valid = 1; setLane(0, 1, 7, 1, 2); setLane(1, 0, 0, 0, 0);
    step(); step();
    in_valid = 0; setCommit(1, 0);
    step();
    flush = 1;
    step();
    in_valid = 1; setLane(0, 1, 9, 7, 7);
    step();
    in_valid = 0;
    checks++;
    if (out_src1_phy[0] !== PW'(32) || out_src2_phy[0] !== PW'(32)) begin
      errors++; $display("FAIL flush_restore: got %0d/%0d want 32/32", out_src1_phy[0], out_src2_phy[0]);
    end
    step();
  endtask

  task automatic test_commit_flush();
    clearInputs(); doReset();
    in_valid = 1;
    for (int g = 0; g < 3; g++) begin
      setLane(0, 1, $urandom_range(1, NA - 1), 0, 0); setLane(1, 1, $urandom_range(1, NA - 1), 0, 0);
      step();
    end
    setCommit(2, 0); flush = 1; randGroup(7);
    step();
    #1;
    checks++;
    if (out_valid !== 1'b0 || free_count !== CW'(FLD)) begin
      errors++; $display("FAIL commit_flush: got ov=%b fc=%0d want 0/%0d", out_valid, free_count, FLD);
    end
    setLane(0, 1, 0, commit_dst_arch[0], commit_dst_arch[1]);
    setLane(1, 1, 0, inflight.size() > 0 ? 0 : 1, 0);
    step();
    in_valid = 0;
    step();
  endtask

  task automatic test_random();
    int n;
    clearInputs(); doReset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      randGroup(7);
      out_ready = $urandom_range(0, 3) != 0;
      n = $urandom_range(0, CWD);
      setCommit(n, $urandom_range(0, 7) == 0);
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    clearInputs();
    step();
  endtask

  task automatic test_back_to_back();
    clearInputs(); doReset();
    in_valid = 1;
    for (int g = 0; g < 20; g++) begin
      randGroup(5);
      if (g > 4) setCommit(2, 0);
      step();
    end
    clearInputs();
    step();
  endtask

  task automatic test_stall_reset();
    clearInputs(); doReset();
    in_valid = 1; setLane(0, 1, 4, 1, 2); setLane(1, 1, 6, 4, 0);
    step();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      randGroup(7);
      step();
    end
    SIG_RST = 1;
    @(posedge SIG_CLK);
    @(negedge SIG_CLK);
    SIG_RST = 0;
    modelReset();
    #1;
    checks++;
    if ({out_valid, out_lane_valid, out_rob_idx, out_dst_phy, out_src1_phy, out_src2_phy, out_prev_phy} !== '0) begin
      errors++; $display("FAIL stall_reset_outputs: got nonzero want zero");
    end
    checks++;
    if (free_count !== CW'(FLD)) begin
      errors++; $display("FAIL stall_reset_fc: got %0d want %0d", free_count, FLD);
    end
    clearInputs();
    step();
  endtask

  initial begin
    SIG_RST = 1;
    clearInputs();
    modelReset();
    @(negedge SIG_CLK);
    test_reset();
    test_single();
    test_dual();
    test_exhaust();
    test_flush();
    test_commit_flush();
    test_back_to_back();
    test_random();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
